imm_extend_stage: RTL and testbench

//  Pipelined, parametrised immediate generator for the decode stage. Takes a raw
//  IMM_W-bit instruction field plus a mode select and produces an XLEN-bit operand
//  (sign/zero/upper/branch/shamt) through a 2-entry skid buffer.

---
 rtl/imm_pkg.sv | 18 +
 rtl/imm_extend_core.sv | 46 ++++
 rtl/imm_extend_stage.sv | 106 ++++++++++
 tb/tb_imm_extend_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-extension stage: mode encodings and
// the legality check used to flag unsupported modes.
package imm_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] IMM_SEXT   = 3'd0;
    localparam logic [MODE_W-1:0] IMM_ZEXT   = 3'd1;
    localparam logic [MODE_W-1:0] IMM_UPPER  = 3'd2;
    localparam logic [MODE_W-1:0] IMM_BRANCH = 3'd3;
    localparam logic [MODE_W-1:0] IMM_SHAMT  = 3'd4;

    // Codes above IMM_SHAMT are reserved and produce an error-flagged zero.
    function automatic logic is_legal_mode(input logic [MODE_W-1:0] mode);
        return (mode <= IMM_SHAMT);
    endfunction

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extender: maps a raw IMM_W-bit field and a mode
// code to an XLEN-bit operand plus an illegal-mode flag.
import imm_pkg::*;

module imm_extend_core #(
    parameter int XLEN      = 32,
    parameter int IMM_W     = 16,
    parameter int BR_SHIFT  = 2,
    parameter int SHAMT_LSB = 6
) (
    input  logic [IMM_W-1:0]  i_imm,
    input  logic [MODE_W-1:0] i_mode,
    output logic [XLEN-1:0]   o_imm,
    output logic              o_err
);

    localparam int SHAMT_W = $clog2(XLEN);

    logic signed [XLEN-1:0] w_sext;
    logic        [XLEN-1:0] w_zext;
    logic        [XLEN-1:0] w_shamt_mask;

    // Base sign/zero extensions; written bitwise so XLEN == IMM_W needs no zero-width replication.
    always_comb begin
        w_sext                = {XLEN{i_imm[IMM_W-1]}};
        w_sext[IMM_W-1:0]     = i_imm;
        w_zext                = '0;
        w_zext[IMM_W-1:0]     = i_imm;
        w_shamt_mask          = (XLEN'(1) << SHAMT_W) - XLEN'(1);
    end

    // Mode select; reserved codes fall through to zero with the error flag set.
    always_comb begin
        o_imm = '0;
        o_err = !is_legal_mode(i_mode);
        case (i_mode)
            IMM_SEXT:   o_imm = w_sext;
            IMM_ZEXT:   o_imm = w_zext;
            IMM_UPPER:  o_imm = w_zext << (XLEN - IMM_W);
            IMM_BRANCH: o_imm = w_sext <<< BR_SHIFT;
            IMM_SHAMT:  o_imm = (w_zext >> SHAMT_LSB) & w_shamt_mask;
            default:    o_imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_stage.sv
// Decode-stage immediate generator: extends the incoming field combinationally
// and registers it into an output register backed by a one-entry skid buffer,
// giving full throughput with a registered in_ready.
import imm_pkg::*;

module imm_extend_stage #(
    parameter int XLEN      = 32,
    parameter int IMM_W     = 16,
    parameter int TAG_W     = 5,
    parameter int BR_SHIFT  = 2,
    parameter int SHAMT_LSB = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [MODE_W-1:0] in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_imm,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    logic [XLEN-1:0]  w_ext_imm;
    logic             w_ext_err;
    logic             w_in_fire;
    logic             w_out_free;

    logic             r_vld_p1;
    logic [XLEN-1:0]  r_imm_p1;
    logic [TAG_W-1:0] r_tag_p1;
    logic             r_err_p1;

    logic             r_skid_vld_p1;
    logic [XLEN-1:0]  r_skid_imm_p1;
    logic [TAG_W-1:0] r_skid_tag_p1;
    logic             r_skid_err_p1;

    imm_extend_core #(
        .XLEN      (XLEN),
        .IMM_W     (IMM_W),
        .BR_SHIFT  (BR_SHIFT),
        .SHAMT_LSB (SHAMT_LSB)
    ) u_core (
        .i_imm  (in_imm),
        .i_mode (in_mode),
        .o_imm  (w_ext_imm),
        .o_err  (w_ext_err)
    );

    // in_ready comes straight from the skid flag so there is no path from out_ready.
    assign in_ready   = !r_skid_vld_p1;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_free = !r_vld_p1 || out_ready;

    // Stage p0 -> p1: output register loads from skid first (FIFO order), else from the extender.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_vld_p1 <= 1'b0;
            r_imm_p1 <= '0;
            r_tag_p1 <= '0;
            r_err_p1 <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_vld_p1) begin
                r_vld_p1 <= 1'b1;
                r_imm_p1 <= r_skid_imm_p1;
                r_tag_p1 <= r_skid_tag_p1;
                r_err_p1 <= r_skid_err_p1;
            end else if (w_in_fire) begin
                r_vld_p1 <= 1'b1;
                r_imm_p1 <= w_ext_imm;
                r_tag_p1 <= in_tag;
                r_err_p1 <= w_ext_err;
            end else begin
                r_vld_p1 <= 1'b0;
            end
        end
    end

    // Skid entry: captures an accepted transaction while the output is stalled, empties when the output drains.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_skid_vld_p1 <= 1'b0;
            r_skid_imm_p1 <= '0;
            r_skid_tag_p1 <= '0;
            r_skid_err_p1 <= 1'b0;
        end else if (w_out_free) begin
            r_skid_vld_p1 <= 1'b0;
        end else if (w_in_fire) begin
            r_skid_vld_p1 <= 1'b1;
            r_skid_imm_p1 <= w_ext_imm;
            r_skid_tag_p1 <= in_tag;
            r_skid_err_p1 <= w_ext_err;
        end
    end

    assign out_valid = r_vld_p1;
    assign out_imm   = r_imm_p1;
    assign out_tag   = r_tag_p1;
    assign out_err   = r_err_p1;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Testbench for imm_extend_stage: directed sequence on a 32/16 instance and a
// 64/12 instance, with a queue-based scoreboard fed from an independent model.
module tb_imm_extend_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, flush;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
    logic [15:0] a_in_imm;
    logic [2:0]  a_in_mode;
    logic [4:0]  a_in_tag, a_out_tag;
    logic [31:0] a_out_imm;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [11:0] b_in_imm;
    logic [2:0]  b_in_mode;
    logic [4:0]  b_in_tag, b_out_tag;
    logic [63:0] b_out_imm;

    imm_extend_stage #(.XLEN(32), .IMM_W(16), .TAG_W(5), .BR_SHIFT(2), .SHAMT_LSB(6)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_imm(a_in_imm),
        .in_mode(a_in_mode), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
        .out_tag(a_out_tag), .out_err(a_out_err)
    );

    imm_extend_stage #(.XLEN(64), .IMM_W(12), .TAG_W(5), .BR_SHIFT(2), .SHAMT_LSB(6)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_imm(b_in_imm),
        .in_mode(b_in_mode), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
        .out_tag(b_out_tag), .out_err(b_out_err)
    );

    typedef struct packed {
        logic [63:0] imm;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   b_sent = 0;

    function automatic exp_t model(input int xlen, input int immw, input logic [15:0] imm,
                                   input logic [2:0] mode, input logic [4:0] tag);
        exp_t        e;
        logic [63:0] z, s, m;
        int          sw;
        z  = 64'(imm) & ((64'd1 << immw) - 64'd1);
        s  = 64'($signed(z << (64 - immw)) >>> (64 - immw));
        m  = (xlen == 64) ? '1 : ((64'd1 << xlen) - 64'd1);
        sw = $clog2(xlen);
        e.tag = tag;
        e.err = 1'b0;
        case (mode)
            3'd0:    e.imm = s & m;
            3'd1:    e.imm = z;
            3'd2:    e.imm = (z << (xlen - immw)) & m;
            3'd3:    e.imm = (s << 2) & m;
            3'd4:    e.imm = (z >> 6) & ((64'd1 << sw) - 64'd1);
            default: begin e.imm = '0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: score outputs and record accepted inputs using pre-edge values, then advance.
    task automatic tick();
        logic a_fin, a_fout, b_fin, b_fout, clr;
        exp_t e;
        a_fin  = a_in_valid && a_in_ready;
        a_fout = a_out_valid && a_out_ready;
        b_fin  = b_in_valid && b_in_ready;
        b_fout = b_out_valid && b_out_ready;
        clr    = reset || flush;
        if (a_fout) begin
            if (qa.size() == 0) chk("a_spurious_out", 64'(a_out_valid), 64'd0);
            else begin
                e = qa.pop_front();
                chk("a_sb_imm", 64'(a_out_imm), e.imm);
                chk("a_sb_tag", 64'(a_out_tag), 64'(e.tag));
                chk("a_sb_err", 64'(a_out_err), 64'(e.err));
            end
        end
        if (b_fout) begin
            if (qb.size() == 0) chk("b_spurious_out", 64'(b_out_valid), 64'd0);
            else begin
                e = qb.pop_front();
                chk("b_sb_imm", b_out_imm, e.imm);
                chk("b_sb_tag", 64'(b_out_tag), 64'(e.tag));
                chk("b_sb_err", 64'(b_out_err), 64'(e.err));
            end
        end
        if (a_fin && !clr) qa.push_back(model(32, 16, a_in_imm, a_in_mode, a_in_tag));
        if (b_fin && !clr) begin
            qb.push_back(model(64, 12, 16'(b_in_imm), b_in_mode, b_in_tag));
            b_sent++;
        end
        @(posedge clk);
        #1;
        if (clr) begin
            qa.delete();
            qb.delete();
        end
    endtask

    task automatic send_a(input logic [15:0] imm, input logic [2:0] mode, input logic [4:0] tag);
        a_in_valid = 1'b1;
        a_in_imm   = imm;
        a_in_mode  = mode;
        a_in_tag   = tag;
    endtask

    initial begin
        int cyc;
        reset = 1'b1; flush = 1'b0;
        a_in_valid = 0; a_in_imm = '0; a_in_mode = '0; a_in_tag = '0; a_out_ready = 1'b1;
        b_in_valid = 0; b_in_imm = '0; b_in_mode = '0; b_in_tag = '0; b_out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_imm",   64'(a_out_imm),   64'd0);
        chk("rst_out_tag",   64'(a_out_tag),   64'd0);
        chk("rst_out_err",   64'(a_out_err),   64'd0);
        chk("rst_in_ready",  64'(a_in_ready),  64'd1);
        chk("rst_b_valid",   64'(b_out_valid), 64'd0);
        chk("rst_b_ready",   64'(b_in_ready),  64'd1);

        // 1: mode sweep with one-cycle latency
        send_a(16'h8000, 3'd0, 5'd1); tick();
        chk("t1_lat_valid", 64'(a_out_valid), 64'd1);
        chk("t1_sext", 64'(a_out_imm), 64'hFFFF8000);
        send_a(16'h8000, 3'd1, 5'd2); tick();
        chk("t1_zext", 64'(a_out_imm), 64'h00008000);
        send_a(16'h8000, 3'd2, 5'd3); tick();
        chk("t1_upper", 64'(a_out_imm), 64'h80000000);
        send_a(16'h8000, 3'd3, 5'd4); tick();
        chk("t1_branch", 64'(a_out_imm), 64'hFFFE0000);
        send_a(16'h07C0, 3'd4, 5'd5); tick();
        chk("t1_shamt", 64'(a_out_imm), 64'h0000001F);
        a_in_valid = 0; tick();
        chk("t1_drained", 64'(a_out_valid), 64'd0);

        // 2: illegal mode still delivered, with error flag and tag
        send_a(16'h1234, 3'd6, 5'd9); tick();
        chk("t2_valid", 64'(a_out_valid), 64'd1);
        chk("t2_imm",   64'(a_out_imm),   64'd0);
        chk("t2_err",   64'(a_out_err),   64'd1);
        chk("t2_tag",   64'(a_out_tag),   64'd9);
        a_in_valid = 0; tick();

        // 3: backpressure fills output and skid, then drains in order
        a_out_ready = 1'b0;
        send_a(16'h0100, 3'd1, 5'd1); tick();
        send_a(16'h0200, 3'd1, 5'd2); tick();
        chk("t3_ready_low", 64'(a_in_ready), 64'd0);
        send_a(16'h0300, 3'd1, 5'd3); tick(); tick();
        chk("t3_stall_ready", 64'(a_in_ready), 64'd0);
        chk("t3_stall_tag",   64'(a_out_tag),  64'd1);
        chk("t3_stall_imm",   64'(a_out_imm),  64'h0100);
        a_out_ready = 1'b1; tick();
        chk("t3_second_tag", 64'(a_out_tag),  64'd2);
        chk("t3_ready_rise", 64'(a_in_ready), 64'd1);
        tick();
        chk("t3_third_tag", 64'(a_out_tag), 64'd3);
        a_in_valid = 0; tick();
        chk("t3_empty", 64'(a_out_valid), 64'd0);

        // 4: flush with output and skid full, plus a request on the same edge
        a_out_ready = 1'b0;
        send_a(16'h0011, 3'd0, 5'd11); tick();
        send_a(16'h0012, 3'd0, 5'd12); tick();
        send_a(16'h0013, 3'd0, 5'd13); flush = 1'b1; tick();
        flush = 1'b0; a_in_valid = 0;
        chk("t4_valid", 64'(a_out_valid), 64'd0);
        chk("t4_ready", 64'(a_in_ready),  64'd1);
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_nothing", 64'(a_out_valid), 64'd0);
        end

        // 5: reset mid-stream, then a clean transaction
        a_out_ready = 1'b0;
        send_a(16'h0AAA, 3'd1, 5'd21); tick();
        send_a(16'h0BBB, 3'd1, 5'd22); reset = 1'b1; tick();
        reset = 1'b0; a_in_valid = 0;
        chk("t5_valid", 64'(a_out_valid), 64'd0);
        chk("t5_imm",   64'(a_out_imm),   64'd0);
        chk("t5_tag",   64'(a_out_tag),   64'd0);
        chk("t5_err",   64'(a_out_err),   64'd0);
        chk("t5_ready", 64'(a_in_ready),  64'd1);
        a_out_ready = 1'b1;
        send_a(16'h0001, 3'd0, 5'd5); tick();
        chk("t5_clean_imm", 64'(a_out_imm), 64'd1);
        chk("t5_clean_tag", 64'(a_out_tag), 64'd5);
        a_in_valid = 0; tick();

        // 6: 64/12 instance, directed then randomized
        b_in_valid = 1'b1; b_in_imm = 12'h800; b_in_mode = 3'd0; b_in_tag = 5'd1; tick();
        chk("t6_sext", b_out_imm, 64'hFFFFFFFFFFFFF800);
        b_in_mode = 3'd2; b_in_tag = 5'd2; tick();
        chk("t6_upper", b_out_imm, 64'h8000000000000000);
        b_in_valid = 0; tick();
        b_sent = 0;
        cyc = 0;
        while ((b_sent < 10000 || qb.size() != 0) && cyc < 60000) begin
            b_in_valid  = (b_sent < 10000) && ($urandom_range(0, 3) != 0);
            b_in_imm    = 12'($urandom);
            b_in_mode   = 3'($urandom_range(0, 7));
            b_in_tag    = 5'($urandom);
            b_out_ready = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
        end
        chk("t6_sent",   64'(b_sent),      64'd10000);
        chk("t6_qempty", 64'(qb.size()),   64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
